// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester mux2 round-robin arbiter.
package mux2_arb_pkg;

    // Channel ownership state: nobody, requester 0, or requester 1.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Smallest hold limit that still lets the counter express "one more cycle".
    localparam int HOLD_MAX_MIN = 2;

endpackage

// File: rtl/mux2.sv
// Existing single-bit 2:1 data mux: sel=1 routes d1, sel=0 routes d0.
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic z
);

    assign z = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select of a shared mux2.
// Grants, sel and preempt are registered; z is the combinational mux2 output.
// Optional feature macro: ARB_TIMEOUT_EN -- bounds how long one owner may hold
// the channel while the other side waits, revoking it with a preempt pulse.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic d0,
    input  logic d1,
    output logic gnt0,
    output logic gnt1,
    output logic sel,
    output logic z,
    output logic preempt
);

    state_t state_r;
    logic   last_r;
    logic   sel_r;
    logic   gnt0_r;
    logic   gnt1_r;
    logic   preempt_r;
    logic   owner_req_s;
    logic   other_req_s;
    logic   timeout_s;

    // Resolve the current owner's request and the competing request.
    always_comb begin
        owner_req_s = 1'b0;
        other_req_s = 1'b0;
        case (state_r)
            OWN0: begin
                owner_req_s = req0;
                other_req_s = req1;
            end
            OWN1: begin
                owner_req_s = req1;
                other_req_s = req0;
            end
            default: begin
                owner_req_s = 1'b0;
                other_req_s = 1'b0;
            end
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    // Clamp keeps the counter at least one bit wide for degenerate settings.
    localparam int HOLD_EFF = (HOLD_MAX < HOLD_MAX_MIN) ? HOLD_MAX_MIN : HOLD_MAX;
    localparam int CNT_W    = $clog2(HOLD_EFF);

    logic [CNT_W-1:0] hold_cnt_r;

    assign timeout_s = owner_req_s && other_req_s &&
                       (hold_cnt_r == CNT_W'(HOLD_EFF - 1));

    // Count cycles the waiting side has been starved; restart on any handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else if (!other_req_s || !owner_req_s || timeout_s) begin
            hold_cnt_r <= {CNT_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Ownership FSM with registered grants, sticky sel and last-served flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            last_r    <= 1'b1;
            sel_r     <= 1'b0;
            gnt0_r    <= 1'b0;
            gnt1_r    <= 1'b0;
            preempt_r <= 1'b0;
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // On a tie the side not served last wins (last=1 favours req0).
                    if (req0 && (!req1 || last_r)) begin
                        state_r <= OWN0;
                        gnt0_r  <= 1'b1;
                        gnt1_r  <= 1'b0;
                        sel_r   <= 1'b0;
                    end else if (req1) begin
                        state_r <= OWN1;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b1;
                        sel_r   <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                    end
                end
                OWN0: begin
                    if (req0 && !timeout_s) begin
                        state_r <= OWN0;
                    end else if (req1) begin
                        // Direct handoff, no idle bubble.
                        state_r   <= OWN1;
                        gnt0_r    <= 1'b0;
                        gnt1_r    <= 1'b1;
                        sel_r     <= 1'b1;
                        last_r    <= 1'b0;
                        preempt_r <= timeout_s;
                    end else begin
                        state_r <= IDLE;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                        last_r  <= 1'b0;
                    end
                end
                OWN1: begin
                    if (req1 && !timeout_s) begin
                        state_r <= OWN1;
                    end else if (req0) begin
                        state_r   <= OWN0;
                        gnt0_r    <= 1'b1;
                        gnt1_r    <= 1'b0;
                        sel_r     <= 1'b0;
                        last_r    <= 1'b1;
                        preempt_r <= timeout_s;
                    end else begin
                        state_r <= IDLE;
                        gnt0_r  <= 1'b0;
                        gnt1_r  <= 1'b0;
                        last_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt0_r  <= 1'b0;
                    gnt1_r  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0    = gnt0_r;
    assign gnt1    = gnt1_r;
    assign sel     = sel_r;
    assign preempt = preempt_r;

    mux2 u_mux2 (
        .d0  (d0),
        .d1  (d1),
        .sel (sel_r),
        .z   (z)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: expectations are queued when
// stimulus is applied and popped when the registered outputs are sampled.
module tb_mux2_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req0 = 1'b0;
    logic req1 = 1'b0;
    logic d0 = 1'b0;
    logic d1 = 1'b0;
    logic gnt0, gnt1, sel, z, preempt;

    typedef struct {
        logic g0;
        logic g1;
        logic s;
        logic p;
    } exp_t;

    typedef struct {
        logic r0;
        logic r1;
        logic g0;
        logic g1;
        logic s;
    } step_t;

    exp_t sb[$];
    logic zq[$];
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    always #10 clk = ~clk;

    mux2_rr_arbiter #(.HOLD_MAX(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (req0),
        .req1    (req1),
        .d0      (d0),
        .d1      (d1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .sel     (sel),
        .z       (z),
        .preempt (preempt)
    );

    task automatic drive(input logic r0, input logic r1);
        @(negedge clk);
        req0 = r0;
        req1 = r1;
    endtask

    task automatic push(input logic g0, input logic g1, input logic s, input logic p);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.s = s; e.p = p;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL reset_hold: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL reset_first_tie: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        drive(1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL reset_release_idle: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
    endtask

    task automatic test_tie_alternation();
        exp_t e;
        logic w;
        // Fresh reset so that the first tie goes to requester 0.
        @(negedge clk);
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 4; r++) begin
            w = (r % 2 == 1);
            drive(1'b1, 1'b1);
            push(!w, w, w, 1'b0);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
                n_err++;
                $display("FAIL tie_round%0d_grant: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                         r, gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
            end
            drive(1'b0, 1'b0);
            push(1'b0, 1'b0, w, 1'b0);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
                n_err++;
                $display("FAIL tie_round%0d_idle: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                         r, gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t  e;
        step_t tbl[9];
        // Starts in IDLE with last=1 (requester 1 served last).
        tbl[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].r0, tbl[i].r1);
            push(tbl[i].g0, tbl[i].g1, tbl[i].s, 1'b0);
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p} || (gnt0 && gnt1)) begin
                n_err++;
                $display("FAIL b2b_step%0d: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                         i, gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
            end
        end
    endtask

    task automatic test_data_path();
        exp_t e;
        logic ez;
        drive(1'b0, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL data_own1: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        // d1 0 -> 1 must reach z; d0 changes must not.
        d1 = 1'b0; d0 = 1'b1; zq.push_back(1'b0);
        #9;
        ez = zq.pop_front();
        n_cmp++;
        if (z !== ez) begin
            n_err++;
            $display("FAIL data_d1_low: z=%b want %b", z, ez);
        end
        d1 = 1'b1; d0 = 1'b0; zq.push_back(1'b1);
        #9;
        ez = zq.pop_front();
        n_cmp++;
        if (z !== ez) begin
            n_err++;
            $display("FAIL data_d1_high: z=%b want %b", z, ez);
        end
        d0 = 1'b1; zq.push_back(1'b1);
        #9;
        ez = zq.pop_front();
        n_cmp++;
        if (z !== ez) begin
            n_err++;
            $display("FAIL data_d0_ignored: z=%b want %b", z, ez);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        // Still in OWN1 with req1 held; pull reset between clock edges.
        tick();
        #4;
        rst_n = 1'b0;
        push(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL async_rst_mid: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL async_rst_regrant: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        drive(1'b0, 1'b0);
        push(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL async_rst_idle: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n;
        logic sw;
        drive(1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL timeout_own0: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
        n = TO_EN ? 9 : 100;
        drive(1'b1, 1'b1);
        for (int i = 1; i <= n; i++) begin
            // With the limit, the 8th waiting cycle hands over with a preempt pulse.
            sw = TO_EN && (i >= 8);
            push(!sw, sw, sw, TO_EN && (i == 8));
            tick();
            e = sb.pop_front();
            n_cmp++;
            if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
                n_err++;
                $display("FAIL timeout_cycle%0d: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                         i, gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
            end
        end
        drive(1'b0, 1'b0);
        push(1'b0, 1'b0, TO_EN, 1'b0);
        tick();
        e = sb.pop_front();
        n_cmp++;
        if ({gnt0, gnt1, sel, preempt} !== {e.g0, e.g1, e.s, e.p}) begin
            n_err++;
            $display("FAIL timeout_release: g0 g1 sel pre = %b %b %b %b, want %b %b %b %b",
                     gnt0, gnt1, sel, preempt, e.g0, e.g1, e.s, e.p);
        end
    endtask

    initial begin
        test_reset();
        test_tie_alternation();
        test_back_to_back();
        test_data_path();
        test_async_reset();
        test_timeout();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
